// File: rtl/skolem_chk_pkg.sv
// Shared types and golden relation for the xor-implies Skolem sweep checker.
package skolem_chk_pkg;

  localparam int N_IN_DEF  = 8;
  localparam int N_OUT_DEF = 8;
  localparam int VEC_COUNT = 1 << N_IN_DEF;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  // y[0] must be the XNOR-reduce of the live inputs, every other live output must be 1.
  function automatic logic golden_ok(input logic [31:0] x, input logic [31:0] y,
                                     input int unsigned nin, input int unsigned nout);
    logic [31:0] xm;
    logic [31:0] hi;
    xm = x & ((32'd1 << nin) - 32'd1);
    hi = ((32'd1 << nout) - 32'd1) & ~32'd1;
    return (y[0] == ~^xm) && ((y & hi) == hi);
  endfunction

endpackage

// File: rtl/skolem_chk_golden.sv
// Combinational golden-relation wrapper; swap this to check another benchmark family.
module skolem_golden
  import skolem_chk_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF
) (
  input  logic [N_IN-1:0]  x,
  input  logic [N_OUT-1:0] y,
  output logic             ok
);
  assign ok = golden_ok(32'(x), 32'(y), N_IN, N_OUT);
endmodule

// File: rtl/skolem_sweep_checker.sv
// Exhaustive sweep of all input vectors through the Skolem block, with a
// one-deep compare stage and a lossless valid/ready mismatch stream.
module skolem_sweep_checker
  import skolem_chk_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_IN-1:0]  x_o,
  input  logic [N_OUT-1:0] y_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    fail_count,
  output logic             mm_valid,
  input  logic             mm_ready,
  output logic [N_IN-1:0]  mm_vec,
  output logic [N_OUT-1:0] mm_y
);

  state_e            state;
  logic              s1_vld;
  logic [N_IN-1:0]   s1_x;
  logic [N_OUT-1:0]  s1_y;
  logic              s1_ok;
  logic              stall;
  logic              s1_mm;

  skolem_golden #(.N_IN(N_IN), .N_OUT(N_OUT)) u_golden (
    .x  (s1_x),
    .y  (s1_y),
    .ok (s1_ok)
  );

  // Freeze the whole pipe only when a new record would collide with an unaccepted one.
  assign stall = mm_valid & ~mm_ready & s1_vld & ~s1_ok;
  assign s1_mm = s1_vld & ~s1_ok & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x_o        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= '0;
      mm_valid   <= 1'b0;
      mm_vec     <= '0;
      mm_y       <= '0;
      s1_vld     <= 1'b0;
      s1_x       <= '0;
      s1_y       <= '0;
    end else begin
      done <= 1'b0;
      if (mm_valid && mm_ready) mm_valid <= 1'b0;
      if (s1_mm) begin
        mm_valid   <= 1'b1;
        mm_vec     <= s1_x;
        mm_y       <= s1_y;
        fail_count <= fail_count + 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          state      <= RUN;
          x_o        <= '0;
          fail_count <= '0;
          pass       <= 1'b0;
          busy       <= 1'b1;
          s1_vld     <= 1'b0;
        end
        RUN: if (!stall) begin
          s1_vld <= 1'b1;
          s1_x   <= x_o;
          s1_y   <= y_i;
          if (&x_o) state <= DRAIN;
          else      x_o   <= x_o + 1'b1;
        end
        DRAIN: if (!stall) begin
          s1_vld <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          pass  <= (fail_count == '0);
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Sweep bench: faulty Skolem models, expected mismatch records queued up front and popped per handshake.
module tb_skolem_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x_o;
  logic [7:0] y_i;
  logic       busy, done, pass;
  logic [8:0] fail_count;
  logic       mm_valid;
  logic       mm_ready = 1'b1;
  logic [7:0] mm_vec, mm_y;

  int errors = 0;
  int checks = 0;
  int mode = 0;

  typedef struct { int mode; int ready_low; int exp_fail; int exp_pass; int exp_lat; } row_t;
  typedef struct { logic [7:0] v; logic [7:0] y; } rec_t;
  row_t rows[4];
  rec_t expq[$];

  skolem_sweep_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_o(x_o), .y_i(y_i),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
    .mm_valid(mm_valid), .mm_ready(mm_ready), .mm_vec(mm_vec), .mm_y(mm_y)
  );

  always #5 clk = ~clk;

  // Skolem block under test: correct, or with a planted fault selected by mode.
  function automatic logic [7:0] model_y(input int m, input logic [7:0] x);
    logic [7:0] y;
    y = {7'h7f, ~^x};
    if (m == 1 && x == 8'h05) y[0] = ~y[0];
    if (m == 2) y[7] = 1'b0;
    if (m == 3 && (x == 8'h03 || x == 8'h04)) y[0] = ~y[0];
    return y;
  endfunction

  always_comb y_i = model_y(mode, x_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_queue(input int m);
    rec_t r;
    expq.delete();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] x, y, g;
      x = 8'(i);
      y = model_y(m, x);
      g = {7'h7f, ^x ? 1'b0 : 1'b1};
      if (y != g) begin
        r.v = x; r.y = y;
        expq.push_back(r);
      end
    end
  endtask

  task automatic run_sweep(input row_t r, input bit hold);
    int lat;
    rec_t e;
    mode = r.mode;
    fill_queue(r.mode);
    @(negedge clk);
    start = 1'b1;
    mm_ready = (r.ready_low == 0);
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("x_after_start", x_o, 0);
    if (!hold) start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 2000; k++) begin
      mm_ready = (k > r.ready_low);
      if (mm_valid && mm_ready) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_record: vec %0h y %0h, none expected", mm_vec, mm_y);
        end else begin
          e = expq.pop_front();
          check("mm_vec", mm_vec, e.v);
          check("mm_y", mm_y, e.y);
        end
      end
      @(negedge clk);
      if (done) begin lat = k; break; end
      if (r.mode == 3 && (k == 10 || k == 19)) check("x_frozen_in_stall", x_o, 8'h05);
    end
    mm_ready = 1'b1;
    check("done_latency", lat, r.exp_lat);
    check("pass", pass, r.exp_pass);
    check("fail_count", fail_count, r.exp_fail);
    check("busy_at_done", busy, 0);
    check("records_left", expq.size(), 0);
  endtask

  initial begin
    rows[0] = '{0, 0, 0, 1, 258};
    rows[1] = '{1, 0, 1, 0, 258};
    rows[2] = '{2, 0, 256, 0, 258};
    rows[3] = '{3, 20, 2, 0, 273};

    #3;
    check("rst_x", x_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail_count", fail_count, 0);
    check("rst_mm_valid", mm_valid, 0);
    check("rst_mm_vec", mm_vec, 0);
    check("rst_mm_y", mm_y, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_sweep(rows[i], 1'b0);

    // start held high: no restart mid-sweep, next sweep only from IDLE
    run_sweep(rows[0], 1'b1);
    @(negedge clk);
    check("restart_from_idle_busy", busy, 1);
    check("restart_from_idle_x", x_o, 0);
    start = 1'b0;

    // asynchronous reset in the middle of the run
    begin
      int n;
      n = 0;
      while (x_o != 8'h40 && n < 200) begin @(negedge clk); n++; end
      check("reached_x40", x_o, 8'h40);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_x", x_o, 0);
    check("arst_busy", busy, 0);
    check("arst_pass", pass, 0);
    check("arst_fail_count", fail_count, 0);
    check("arst_mm_valid", mm_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(rows[0], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
